pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set width of the payload data field.
REQ-002 Parameter CTRL_W, default 2, SHALL set width of the control field (e.g. memToReg, regWrite), which is zeroed on bubbles.
REQ-003 Parameter SKID, default 1, SHALL select the buffer mode: 1 = two-entry skid buffer, 0 = single register with combinational ready.
REQ-004 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 flush  input  1  SHALL be a synchronous kill of all held entries.
REQ-007 in_valid  input  1  SHALL mean the upstream stage presents an entry.
REQ-008 in_ready  output  1  SHALL mean this stage accepts an entry this cycle.
REQ-009 in_ctrl  input  CTRL_W  SHALL be the upstream control bits.
REQ-010 in_data  input  DATA_W  SHALL be the upstream payload (ALU result, memory data, rd, ...).
REQ-011 out_valid  output  1  SHALL mean the head entry is valid.
REQ-012 out_ready  input  1  SHALL mean the downstream stage consumes the head entry.
REQ-013 out_ctrl  output  CTRL_W  SHALL be the head-entry control bits, registered.
REQ-014 out_data  output  DATA_W  SHALL be the head-entry payload, registered.
REQ-015 occupancy  output  2  SHALL report held entries (0, 1 or 2).

Function
REQ-016 Input transfer SHALL occur iff in_valid && in_ready at a rising edge; output transfer iff out_valid && out_ready.
REQ-017 Entries SHALL leave in arrival order, with no loss or duplication.
REQ-018 SKID=1: state machine SHALL have states EMPTY, ONE and TWO, held in a main register (head) and a skid register.
REQ-019 SKID=1: in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded from registered state only (no out_ready-to-in_ready path).
REQ-020 EMPTY with an input transfer SHALL load main and go to ONE; otherwise it stays in EMPTY.
REQ-021 ONE with both transfers SHALL load main from input and stay in ONE (throughput 1/cycle).
REQ-022 ONE with an input transfer only SHALL load skid and go to TWO; with an output transfer only it SHALL go to EMPTY.
REQ-023 TWO with an output transfer SHALL move skid to main and go to ONE; otherwise it holds.
REQ-024 SKID=0: one register SHALL be used, with in_ready = !out_valid || out_ready (combinational), and occupancy SHALL never exceed 1.
REQ-025 Latency SHALL be 1 cycle from input transfer to out_valid when the stage is empty.
REQ-026 out_valid SHALL equal (state != EMPTY).
REQ-027 Whenever out_valid=0, out_ctrl SHALL be all-zero (bubble), achieved by clearing the main ctrl register on entry to EMPTY.
REQ-028 out_data SHALL retain its last value when the stage is empty; it is don't-care to consumers.
REQ-029 flush=1 SHALL force EMPTY and zero both ctrl registers next cycle, and data registers SHALL be retained.
REQ-030 An input transfer coinciding with flush SHALL be discarded; flush SHALL have priority over both transfers.
REQ-031 in_ready during a flush cycle SHALL follow the normal rules (REQ-019/REQ-024).
REQ-032 occupancy SHALL be 0/1/2 for EMPTY/ONE/TWO, updated on the same edge as state.

Reset
REQ-033 reset=1 SHALL drive state to EMPTY and clear all ctrl and data registers to 0 at the next edge.
REQ-034 Reset SHALL take priority over flush and over both transfers, including when asserted mid-operation in TWO.
REQ-035 After reset: out_valid=0, out_ctrl=0, out_data=0, occupancy=0; in_ready=1 (SKID=1) or 1 (SKID=0).

Verification
REQ-036 Streaming: SKID=1, out_ready=1, send data 1..8 with ctrl=2'b11 back-to-back -> out_data 1..8 each one cycle later, in_ready constantly 1.
REQ-037 Skid fill: SKID=1, out_ready=0, send 0xA then 0xB -> occupancy=2, in_ready=0; raise out_ready -> 0xA then 0xB delivered, in_ready=1 the cycle after 0xA leaves.
REQ-038 Bubble: in_valid=0 with out_ready=1 after one entry -> out_valid=0 and out_ctrl=2'b00 the next cycle, out_data unchanged.
REQ-039 Flush: TWO state plus flush with simultaneous in_valid=1 data 0xC -> next cycle occupancy=0 and out_ctrl=0, and 0xC is never emitted.
REQ-040 Reset mid-operation: TWO state, reset=1 with flush=1 and out_ready=1 -> next cycle all outputs 0, occupancy=0, in_ready=1.
REQ-041 SKID=0: out_ready=0 holding entry 0x5 -> in_ready=0; toggle out_ready=1 with in_valid=1 data 0x6 -> 0x6 loaded same edge 0x5 leaves.

Source files
------------

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage -- valid/ready pipeline register stage with optional skid entry.
//
// Carries a payload (in_data) and a control field (in_ctrl) from one pipeline
// stage to the next. The control field is forced to zero whenever the stage
// presents no entry, so a bubble never carries live control bits (regWrite,
// memToReg, ...) downstream.
//
// SKID = 1 : two-entry skid buffer (main = head, skid = overflow). in_ready is
//            decoded from registered state only, which breaks the combinational
//            out_ready -> in_ready path between stages.
// SKID = 0 : single register; in_ready = !out_valid || out_ready.
//
// Ports
//   clock      in   single clock, rising edge
//   reset      in   synchronous, active-high; clears state, ctrl and data
//   flush      in   synchronous kill of all held entries (data retained)
//   in_valid   in   upstream presents an entry
//   in_ready   out  this stage accepts an entry this cycle
//   in_ctrl    in   [CTRL_W] upstream control bits
//   in_data    in   [DATA_W] upstream payload
//   out_valid  out  head entry is valid
//   out_ready  in   downstream consumes the head entry
//   out_ctrl   out  [CTRL_W] head control bits (zero when out_valid = 0)
//   out_data   out  [DATA_W] head payload (holds last value when empty)
//   occupancy  out  [2] number of held entries (0, 1 or 2)
// -----------------------------------------------------------------------------
module pipe_stage #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding equals the number of held entries, so occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic in_xfer;
  logic out_xfer;

  // Datapath load controls produced by the next-state logic.
  logic main_load_in;    // main <= input
  logic main_load_skid;  // main <= skid (skid entry advances to head)
  logic main_clr_ctrl;   // head leaves with nothing behind it: make a bubble
  logic skid_load;       // skid <= input (head is stalled)

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign out_valid = (state != EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = state;

  generate
    if (SKID != 0) begin : g_ready_skid
      // Registered-only decode: no out_ready term reaches in_ready.
      assign in_ready = (state != TWO);
    end else begin : g_ready_reg
      // Single register: a consumed head frees the slot in the same cycle.
      assign in_ready = (state == EMPTY) || out_ready;
    end
  endgenerate

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    state_nxt      = state;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    main_clr_ctrl  = 1'b0;
    skid_load      = 1'b0;

    if (flush) begin
      // Flush outranks both transfers; any coincident input is dropped.
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_load_in = 1'b1;
            state_nxt    = ONE;
          end
        end

        ONE: begin
          if (in_xfer && out_xfer) begin
            // Head leaves while the new entry takes its place: full rate.
            main_load_in = 1'b1;
          end else if (in_xfer) begin
            // Head is stalled; park the new entry behind it. With SKID = 0
            // in_ready requires out_ready here, so this branch is unreachable.
            if (SKID != 0) begin
              skid_load = 1'b1;
              state_nxt = TWO;
            end
          end else if (out_xfer) begin
            main_clr_ctrl = 1'b1;
            state_nxt     = EMPTY;
          end
        end

        TWO: begin
          // in_ready is 0 here, so only the output side can move.
          if (out_xfer) begin
            main_load_skid = 1'b1;
            state_nxt      = ONE;
          end
        end

        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Main (head) register
  // ---------------------------------------------------------------------------
  // Flush clears only the control bits so a killed entry becomes a bubble;
  // the payload is don't-care when empty and is left alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
    end else if (main_load_in) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end else if (main_load_skid) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
    end else if (main_clr_ctrl) begin
      main_ctrl <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Skid register (present only in skid-buffer mode)
  // ---------------------------------------------------------------------------
  generate
    if (SKID != 0) begin : g_skid
      always_ff @(posedge clock) begin
        if (reset) begin
          skid_ctrl <= '0;
          skid_data <= '0;
        end else if (flush) begin
          skid_ctrl <= '0;
        end else if (skid_load) begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end
      end
    end else begin : g_no_skid
      assign skid_ctrl = '0;
      assign skid_data = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage -- drives a skid-buffer instance (SKID=1) and a single-register
// instance (SKID=0) with the same stimulus and compares each against its own
// queue-based reference model: a FIFO of capacity 2 (ready while not full) or
// capacity 1 (ready while empty or being drained).
// -----------------------------------------------------------------------------
module tb_pipe_stage;

  localparam int DW = 64;
  localparam int CW = 2;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          rdy1, ov1, rdy0, ov0;
  logic [CW-1:0] oc1, oc0;
  logic [DW-1:0] od1, od0;
  logic [1:0]    occ1, occ0;

  always #5 clock = ~clock;

  pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
    .occupancy(occ1)
  );

  pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_reg (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
    .occupancy(occ0)
  );

  // Reference model state
  ent_t          q1[$];
  ent_t          q0[$];
  logic [DW-1:0] shown1;
  logic [DW-1:0] shown0;
  bit            armed = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check settled outputs against the
  // model, then advance the model across the rising edge.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [CW-1:0] ic, input logic [DW-1:0] id,
                      input logic ordy);
    bit   acc1, acc0, pop1, pop0;
    ent_t e;
    @(negedge clock);
    reset     = r;
    flush     = f;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    #1;
    if (armed) begin
      check("skid.out_valid", DW'(ov1), DW'(q1.size() > 0));
      check("skid.out_ctrl",  DW'(oc1), (q1.size() > 0) ? DW'(q1[0].c) : '0);
      check("skid.out_data",  od1,      (q1.size() > 0) ? q1[0].d : shown1);
      check("skid.occupancy", DW'(occ1), DW'(q1.size()));
      check("skid.in_ready",  DW'(rdy1), DW'(q1.size() < 2));
      check("reg.out_valid",  DW'(ov0), DW'(q0.size() > 0));
      check("reg.out_ctrl",   DW'(oc0), (q0.size() > 0) ? DW'(q0[0].c) : '0);
      check("reg.out_data",   od0,      (q0.size() > 0) ? q0[0].d : shown0);
      check("reg.occupancy",  DW'(occ0), DW'(q0.size()));
      check("reg.in_ready",   DW'(rdy0), DW'((q0.size() == 0) || ordy));
    end
    acc1 = iv && (q1.size() < 2);
    acc0 = iv && ((q0.size() == 0) || ordy);
    pop1 = (q1.size() > 0) && ordy;
    pop0 = (q0.size() > 0) && ordy;
    e.c  = ic;
    e.d  = id;
    @(posedge clock);
    if (r) begin
      q1.delete(); q0.delete();
      shown1 = '0; shown0 = '0;
      armed  = 1'b1;
    end else if (f) begin
      q1.delete(); q0.delete();
    end else begin
      if (pop1) void'(q1.pop_front());
      if (pop0) void'(q0.pop_front());
      if (acc1) q1.push_back(e);
      if (acc0) q0.push_back(e);
    end
    if (q1.size() > 0) shown1 = q1[0].d;
    if (q0.size() > 0) shown0 = q0[0].d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_ctrl = '0; in_data = '0; out_ready = 1'b0;

    // Reset, then post-reset state is checked on the next step.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Streaming 1..8 with ctrl 2'b11 at full rate.
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 2'b11, DW'(i), 1);
    // Bubble after the stream: empty, ctrl zero, data held at 8.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Skid fill: 0xA then 0xB with the consumer stalled, then drain.
    step(0, 0, 1, 2'b01, 64'hA, 0);
    step(0, 0, 1, 2'b10, 64'hB, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Flush in TWO with a coincident input 0xC.
    step(0, 0, 1, 2'b01, 64'h1, 0);
    step(0, 0, 1, 2'b10, 64'h2, 0);
    step(0, 1, 1, 2'b11, 64'hC, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Reset in TWO, together with flush, input and out_ready.
    step(0, 0, 1, 2'b11, 64'h3, 0);
    step(0, 0, 1, 2'b11, 64'h4, 0);
    step(1, 1, 1, 2'b11, 64'hD, 1);
    step(0, 0, 0, 0, 0, 0);

    // Single-register swap: 0x6 loads on the edge 0x5 leaves.
    step(0, 0, 1, 2'b01, 64'h5, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2'b10, 64'h6, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
           CW'($urandom), {$urandom, $urandom}, ($urandom % 3) != 0);
    end
    step(0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
